// File: rtl/mvau_pkg.sv
// Shared types for the MVAU weight path: weight word, weight-memory address and FIFO entry.
// The word and address widths are fixed here so every block agrees on them.
package mvau_pkg;

  localparam int SIMD         = 2;
  localparam int TW           = 1;
  localparam int WMEM_ADDR_BW = 4;

  typedef logic [SIMD*TW-1:0]      weight_t;
  typedef logic [WMEM_ADDR_BW-1:0] wmem_addr_t;

  typedef struct packed {
    logic    last;
    weight_t data;
  } fifo_entry_t;

endpackage

// File: rtl/mvau_weight_fifo.sv
// Small synchronous FIFO of {last, data} weight beats with flush and occupancy output.
// The producer never pushes into a full FIFO, so a push needs no full check.
module mvau_weight_fifo
  import mvau_pkg::*;
#(
  parameter  int FIFO_DEPTH = 3,
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        empty,
  output logic [OCC_W-1:0] occ
);

  fifo_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;

  // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
  assign wr_ptr_nxt = (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_nxt = (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

  assign head  = mem[rd_ptr];
  assign empty = (occ == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr_nxt;
      end
      if (pop) rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/mvau_weight_streamer.sv
// Drives the weight-memory read address and turns the 1-cycle registered read data into
// a valid/ready weight stream, using FIFO credits so no beat is ever lost or duplicated.
module mvau_weight_streamer
  import mvau_pkg::*;
#(
  parameter int WMEM_DEPTH = 4,
  parameter int FIFO_DEPTH = 3
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       en,
  input  logic       restart,
  output wmem_addr_t wmem_addr,
  input  weight_t    wmem_out,
  output weight_t    m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic             rd_pend;
  logic             pend_last;
  logic             issue;
  logic             addr_at_end;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   credits_used;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  fifo_entry_t      fifo_din;
  fifo_entry_t      fifo_head;

  // An in-flight read reserves a FIFO slot, so issue never has to look at tready.
  assign credits_used = {1'b0, occ} + {{OCC_W{1'b0}}, rd_pend};
  assign issue        = en & ~restart & (credits_used < (OCC_W+1)'(FIFO_DEPTH));
  assign addr_at_end  = (wmem_addr == WMEM_ADDR_BW'(WMEM_DEPTH - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wmem_addr <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
    end else if (restart) begin
      wmem_addr <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
    end else if (issue) begin
      rd_pend   <= 1'b1;
      pend_last <= addr_at_end;
      wmem_addr <= addr_at_end ? '0 : wmem_addr + 1'b1;
    end else begin
      rd_pend   <= 1'b0;
    end
  end

  assign fifo_din.last = pend_last;
  assign fifo_din.data = wmem_out;
  assign fifo_push     = rd_pend & ~restart;
  assign fifo_pop      = m_axis_tvalid & m_axis_tready & ~restart;

  mvau_weight_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .flush   (restart),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .occ     (occ)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_head.data;
  assign m_axis_tlast  = fifo_head.last;

endmodule

// File: tb/tb_mvau_weight_streamer.sv
// Randomised scoreboard bench for mvau_weight_streamer: a credit-level model predicts the
// beat stream and an independent monitor checks every handshake and the valid/address outputs.
module tb_mvau_weight_streamer;
  import mvau_pkg::*;

  localparam int D  = 4;
  localparam int FD = 3;

  logic       aclk    = 1'b0;
  logic       aresetn = 1'b0;
  logic       en      = 1'b0;
  logic       restart = 1'b0;
  logic       tready  = 1'b0;
  wmem_addr_t wmem_addr;
  weight_t    wmem_out;
  weight_t    tdata;
  logic       tvalid;
  logic       tlast;

  weight_t     wmem [D];
  fifo_entry_t exp_q [$];
  fifo_entry_t exp_e;
  int          m_buf;
  int          m_pend;
  int          m_addr;
  int          m_pop;
  bit          m_issue;
  int          beats;
  int          compared   = 0;
  int          mismatched = 0;

  mvau_weight_streamer #(
    .WMEM_DEPTH(D),
    .FIFO_DEPTH(FD)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .en            (en),
    .restart       (restart),
    .wmem_addr     (wmem_addr),
    .wmem_out      (wmem_out),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  always #5 aclk = ~aclk;

  // Registered-read weight memory holding words 0,1,2,3.
  initial for (int i = 0; i < D; i++) wmem[i] = weight_t'(i);
  always @(posedge aclk) wmem_out <= wmem[wmem_addr[1:0]];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts buffered beats and the one in-flight read; every issued read
  // appends the word of the next address in the pass to the expected stream.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn || restart) begin
      exp_q.delete();
      m_buf  = 0;
      m_pend = 0;
      m_addr = 0;
    end else begin
      m_pop   = (m_buf > 0 && tready) ? 1 : 0;
      m_issue = en && (m_buf + m_pend < FD);
      m_buf   = m_buf - m_pop + m_pend;
      m_pend  = m_issue ? 1 : 0;
      if (m_issue) begin
        exp_q.push_back('{last: (m_addr == D - 1), data: wmem[m_addr]});
        m_addr = (m_addr + 1) % D;
      end
    end
  end

  // Monitor: samples mid-cycle and consumes one expected beat per DUT handshake.
  always @(negedge aclk) begin
    if (aresetn) begin
      check_output("tvalid", tvalid, (m_buf > 0));
      check_output("wmem_addr", wmem_addr, m_addr);
      if (tvalid && tready && !restart) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_beat", 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check_output("tdata", tdata, exp_e.data);
          check_output("tlast", tlast, exp_e.last);
          beats++;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic e, input logic r, input logic t);
    @(posedge aclk);
    #1;
    en      = e;
    restart = r;
    tready  = t;
  endtask

  initial begin
    int start;
    int cyc;
    beats = 0;

    #12;
    check_output("reset_tvalid", tvalid, 0);
    check_output("reset_tlast", tlast, 0);
    check_output("reset_tdata", tdata, 0);
    check_output("reset_addr", wmem_addr, 0);
    aresetn = 1'b1;

    $display("[TB] free-running stream");
    repeat (14) apply_stimulus(1, 0, 1);

    $display("[TB] backpressure stall");
    apply_stimulus(0, 1, 1);
    repeat (10) apply_stimulus(1, 0, 0);
    check_output("stall_tdata", tdata, 0);
    check_output("stall_addr", wmem_addr, 3);
    repeat (8) apply_stimulus(1, 0, 1);

    $display("[TB] random backpressure");
    start = beats;
    cyc   = 0;
    while (beats < start + 1000 && cyc < 6000) begin
      apply_stimulus(1, 0, $urandom_range(0, 1) == 1);
      cyc++;
    end
    check_output("random_beats_done", (beats >= start + 1000), 1);

    $display("[TB] single enable pulse");
    apply_stimulus(0, 1, 1);
    apply_stimulus(1, 0, 1);
    start = beats;
    repeat (6) apply_stimulus(0, 0, 1);
    check_output("pulse_beats", beats - start, 1);
    check_output("pulse_addr", wmem_addr, 1);

    $display("[TB] restart with buffered and in-flight beats");
    apply_stimulus(0, 1, 0);
    repeat (3) apply_stimulus(1, 0, 0);
    check_output("pre_restart_tvalid", tvalid, 1);
    apply_stimulus(1, 1, 0);
    apply_stimulus(0, 0, 1);
    check_output("post_restart_tvalid", tvalid, 0);
    repeat (8) apply_stimulus(1, 0, 1);

    $display("[TB] asynchronous reset mid-stream");
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check_output("areset_tvalid", tvalid, 0);
    check_output("areset_tlast", tlast, 0);
    check_output("areset_addr", wmem_addr, 0);
    check_output("areset_tdata", tdata, 0);
    @(negedge aclk);
    #2;
    aresetn = 1'b1;
    repeat (12) apply_stimulus(1, 0, 1);

    repeat (6) apply_stimulus(0, 0, 1);
    check_output("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
